// File: rtl/conv_engine_n_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pkg
// Shared types and helpers for the CNN convolution engine:
//   state_t      - engine FSM states
//   FRAME_LEN_*  - results-per-frame defaults for each network layer
//   sat_add      - ACC_W-wide signed add, wrapping or saturating
// -----------------------------------------------------------------------------
package cnn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    // Output positions per frame for each layer (valid-mode convolutions).
    localparam int FRAME_LEN_L1 = 676;  // 26 x 26
    localparam int FRAME_LEN_L2 = 144;  // 12 x 12
    localparam int FRAME_LEN_L3 = 25;   //  5 x  5

    // Adds two signed operands carried in 64 bits and returns the result as an
    // acc_w-bit signed value, sign-extended back to 64 bits. Operands are far
    // below 2^62 for any sensible acc_w, so the 64-bit sum itself never
    // overflows. sat=1 clamps to the signed acc_w range; sat=0 wraps.
    function automatic longint sat_add(input longint a, input longint b,
                                       input int acc_w, input bit sat);
        longint hi;
        longint lo;
        longint sum;
        longint result;
        hi  = (longint'(1) <<< (acc_w - 1)) - 1;
        lo  = -(longint'(1) <<< (acc_w - 1));
        sum = a + b;
        if (sat) begin
            if (sum > hi)      result = hi;
            else if (sum < lo) result = lo;
            else               result = sum;
        end else begin
            // Keep the low acc_w bits and re-extend their sign.
            result = (sum <<< (64 - acc_w)) >>> (64 - acc_w);
        end
        return result;
    endfunction

endpackage

// File: rtl/conv_engine_n_if.sv
// -----------------------------------------------------------------------------
// conv_engine_n_if
// Window-in / result-out handshake bundle of the convolution engine.
//   win_vld/win_rdy/win/relu_en : one K x K window per handshake
//   res_vld/res_rdy/res/res_last: first-word-fall-through result stream
// modport master: window producer + result consumer
// modport slave : the engine
// -----------------------------------------------------------------------------
interface conv_engine_n_if #(
    parameter int K      = 3,
    parameter int OUT_CH = 2,
    parameter int DIN_W  = 2,
    parameter int ACC_W  = 18
);
    logic                      win_vld;
    logic                      win_rdy;
    logic [K*K*DIN_W-1:0]      win;
    logic                      relu_en;
    logic                      res_vld;
    logic                      res_rdy;
    logic [OUT_CH*ACC_W-1:0]   res;
    logic                      res_last;

    modport master (
        output win_vld, win, relu_en, res_rdy,
        input  win_rdy, res_vld, res, res_last
    );

    modport slave (
        input  win_vld, win, relu_en, res_rdy,
        output win_rdy, res_vld, res, res_last
    );
endinterface

// File: rtl/conv_engine_n_fifo.sv
// -----------------------------------------------------------------------------
// cnn_fifo
// Synchronous first-word-fall-through FIFO with synchronous flush.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous flush (empties the FIFO)
//   push, din  : write port (ignored when full)
//   pop        : read acknowledge (ignored when empty)
//   dout       : head entry, forced to 0 while empty
//   empty, full: occupancy flags
// DEPTH must be a power of two (pointers wrap naturally), DEPTH >= 2.
// -----------------------------------------------------------------------------
module cnn_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          empty,
    output logic          full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: ;
            endcase
        end
    end

    // NOTE: the storage array has no reset; only the pointers and count do.
    // Stale words are never observable because dout is masked while empty.
    always_ff @(posedge clk) begin
        if (push_ok && !clr) mem[wr_ptr] <= din;
    end

    assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/conv_engine_n.sv
// -----------------------------------------------------------------------------
// conv_engine_n
// K x K convolution engine computing OUT_CH channels in parallel, one kernel
// row per cycle, followed by bias add, optional ReLU and an output FIFO that
// tags the last result of every frame.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr         : synchronous flush; aborts the current window, empties FIFO,
//                 restarts the frame count
//   bus         : window / result handshakes (conv_engine_n_if.slave)
//   wt_row_idx  : kernel row addressed in the external weight ROMs
//   wt_row      : weights for that row, ch o col c at [(o*K+c)*WT_W +: WT_W]
//   bias        : per-channel signed bias, static during a frame
//   busy        : engine is not idle
// A window accepted on edge E has its result visible from edge E+K+1.
// -----------------------------------------------------------------------------
module conv_engine_n
    import cnn_pkg::*;
#(
    parameter int K          = 3,
    parameter int OUT_CH     = 2,
    parameter int DIN_W      = 2,
    parameter int WT_W       = 9,
    parameter int ACC_W      = 18,
    parameter int SAT        = 0,
    parameter int FIFO_DEPTH = 4,
    parameter int FRAME_LEN  = FRAME_LEN_L1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    conv_engine_n_if.slave           bus,
    output logic [$clog2(K)-1:0]     wt_row_idx,
    input  logic [OUT_CH*K*WT_W-1:0] wt_row,
    input  logic [OUT_CH*WT_W-1:0]   bias,
    output logic                     busy
);
    localparam int RW   = $clog2(K);
    localparam int FC_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [RW-1:0]   LAST_ROW   = RW'(K - 1);
    localparam logic [FC_W-1:0] LAST_FRAME = FC_W'(FRAME_LEN - 1);
    localparam bit              SAT_EN     = (SAT != 0);

    state_t                    state_q;
    state_t                    state_d;
    logic [RW-1:0]             row_q;
    logic [K*K*DIN_W-1:0]      win_q;
    logic                      relu_q;
    logic [FC_W-1:0]           frame_q;
    logic signed [ACC_W-1:0]   acc_q [OUT_CH];

    logic                      win_rdy_c;
    logic                      accept;
    logic                      push;
    logic                      last_row;
    logic                      push_last;
    logic [OUT_CH*ACC_W-1:0]   push_data;
    logic                      fifo_empty;
    logic                      fifo_full;

    assign last_row  = (row_q == LAST_ROW);
    assign push_last = (frame_q == LAST_FRAME);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   state_q <= ST_IDLE;
        else if (clr) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned (which would infer a latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.win_vld && !fifo_full) state_d = ST_MAC;
            ST_MAC:   if (last_row)                  state_d = ST_WRITE;
            ST_WRITE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        win_rdy_c  = 1'b0;
        accept     = 1'b0;
        push       = 1'b0;
        wt_row_idx = '0;
        busy       = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                // Fullness is checked here so the later push always has room.
                win_rdy_c = !fifo_full;
                accept    = bus.win_vld && !fifo_full;
            end
            ST_MAC:   wt_row_idx = row_q;
            ST_WRITE: push       = 1'b1;
            default:  ;
        endcase
    end

    assign bus.win_rdy = win_rdy_c;

    // ---------------- window capture, row and frame counters ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q   <= '0;
            win_q   <= '0;
            relu_q  <= 1'b0;
            frame_q <= '0;
        end else if (clr) begin
            row_q   <= '0;
            frame_q <= '0;
        end else begin
            if (accept) begin
                row_q  <= '0;
                win_q  <= bus.win;
                relu_q <= bus.relu_en;
            end else if (state_q == ST_MAC && !last_row) begin
                row_q <= row_q + RW'(1);
            end
            if (push) frame_q <= push_last ? '0 : frame_q + FC_W'(1);
        end
    end

    // ---------------- per-channel MAC, bias and ReLU ----------------
    for (genvar o = 0; o < OUT_CH; o++) begin : g_ch
        longint                  mac_sum;
        longint                  y_sum;
        logic signed [ACC_W-1:0] mac_next;

        // Products are exact in 64 bits; each partial sum goes through
        // sat_add so saturation applies per add, not once at the end.
        always_comb begin
            mac_sum = longint'(acc_q[o]);
            for (int c = 0; c < K; c++) begin
                mac_sum = sat_add(mac_sum,
                    longint'(win_q[(int'(row_q) * K + c) * DIN_W +: DIN_W]) *
                    longint'($signed(wt_row[(o * K + c) * WT_W +: WT_W])),
                    ACC_W, SAT_EN);
            end
            mac_next = ACC_W'(mac_sum);
        end

        always_comb begin
            y_sum = sat_add(longint'(acc_q[o]),
                            longint'($signed(bias[o * WT_W +: WT_W])),
                            ACC_W, SAT_EN);
            if (relu_q && y_sum < 0) y_sum = 0;
        end

        assign push_data[o * ACC_W +: ACC_W] = ACC_W'(y_sum);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                 acc_q[o] <= '0;
            else if (clr || accept)     acc_q[o] <= '0;
            else if (state_q == ST_MAC) acc_q[o] <= mac_next;
        end
    end

    // ---------------- output FIFO ----------------
    cnn_fifo #(
        .DW    (OUT_CH * ACC_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .push  (push),
        .din   ({push_last, push_data}),
        .pop   (bus.res_rdy),
        .dout  ({bus.res_last, bus.res}),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign bus.res_vld = !fifo_empty;

endmodule

// File: tb/tb_conv_engine_n.sv
// -----------------------------------------------------------------------------
// tb_conv_engine_n
// Scoreboard bench: every accepted window pushes its hand-computed result onto
// a per-DUT queue; monitors pop and compare whenever a DUT presents a result.
//   dut0 : ACC_W=18, SAT=0, FIFO_DEPTH=4, FRAME_LEN=3 (main engine)
//   dut1 : ACC_W=12, SAT=1   (saturating arithmetic)
//   dut2 : ACC_W=12, SAT=0   (wrapping arithmetic)
// -----------------------------------------------------------------------------
module tb_conv_engine_n;
    localparam int K = 3, OUT_CH = 2, DIN_W = 2, WT_W = 9;
    localparam int WIN_W = K * K * DIN_W;
    localparam int ROW_W = OUT_CH * K * WT_W;

    typedef struct packed {
        logic [63:0] res;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    conv_engine_n_if #(.K(K), .OUT_CH(OUT_CH), .DIN_W(DIN_W), .ACC_W(18)) if0 ();
    conv_engine_n_if #(.K(K), .OUT_CH(OUT_CH), .DIN_W(DIN_W), .ACC_W(12)) if1 ();
    conv_engine_n_if #(.K(K), .OUT_CH(OUT_CH), .DIN_W(DIN_W), .ACC_W(12)) if2 ();

    logic [1:0]             wt_idx0, wt_idx1, wt_idx2;
    logic [ROW_W-1:0]       wt_row0, wt_row1, wt_row2;
    logic [OUT_CH*WT_W-1:0] bias0, bias_s;
    logic                   busy0, busy1, busy2;
    int                     wt_sel0 = 0;
    int                     wt_sel_s = 0;

    // Weight ROM model: sel picks a table, r is the addressed kernel row.
    function automatic logic [ROW_W-1:0] rom(input int sel, input int r);
        logic [ROW_W-1:0] v;
        int w;
        v = '0;
        for (int o = 0; o < OUT_CH; o++) begin
            for (int c = 0; c < K; c++) begin
                case (sel)
                    0:       w = (o == 0) ? 1 : -1;
                    1:       w = (o == 0) ? r + 1 : c - 1;
                    2:       w = (o == 0) ? -256 : 255;
                    default: w = 255;
                endcase
                v[(o * K + c) * WT_W +: WT_W] = WT_W'(w);
            end
        end
        return v;
    endfunction

    assign wt_row0 = rom(wt_sel0, int'(wt_idx0));
    assign wt_row1 = rom(wt_sel_s, int'(wt_idx1));
    assign wt_row2 = rom(wt_sel_s, int'(wt_idx2));

    conv_engine_n #(.K(K), .OUT_CH(OUT_CH), .DIN_W(DIN_W), .WT_W(WT_W), .ACC_W(18),
                    .SAT(0), .FIFO_DEPTH(4), .FRAME_LEN(3)) dut0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .bus(if0),
        .wt_row_idx(wt_idx0), .wt_row(wt_row0), .bias(bias0), .busy(busy0));
    conv_engine_n #(.K(K), .OUT_CH(OUT_CH), .DIN_W(DIN_W), .WT_W(WT_W), .ACC_W(12),
                    .SAT(1), .FIFO_DEPTH(4), .FRAME_LEN(676)) dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .bus(if1),
        .wt_row_idx(wt_idx1), .wt_row(wt_row1), .bias(bias_s), .busy(busy1));
    conv_engine_n #(.K(K), .OUT_CH(OUT_CH), .DIN_W(DIN_W), .WT_W(WT_W), .ACC_W(12),
                    .SAT(0), .FIFO_DEPTH(4), .FRAME_LEN(676)) dut2 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .bus(if2),
        .wt_row_idx(wt_idx2), .wt_row(wt_row2), .bias(bias_s), .busy(busy2));

    // ---------------- scoreboard ----------------
    int   n_vec = 0;
    int   n_err = 0;
    exp_t q0 [$];
    exp_t q1 [$];
    exp_t q2 [$];
    int   fidx [3] = '{0, 0, 0};
    int   flen [3] = '{3, 676, 676};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] pack2(input longint c0, input longint c1, input int w);
        logic [63:0] mask;
        mask = (64'(1) << w) - 64'(1);
        return ((64'(c1) & mask) << w) | (64'(c0) & mask);
    endfunction

    task automatic push_exp(input int id, input longint c0, input longint c1);
        exp_t e;
        e.res  = pack2(c0, c1, (id == 0) ? 18 : 12);
        e.last = (fidx[id] == flen[id] - 1);
        fidx[id] = e.last ? 0 : fidx[id] + 1;
        case (id)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic flush_exp();
        q0.delete();
        q1.delete();
        q2.delete();
        fidx = '{0, 0, 0};
    endtask

    task automatic check_out(input int id, input logic [63:0] act_res, input logic act_last);
        exp_t e;
        int   sz;
        sz = (id == 0) ? q0.size() : (id == 1) ? q1.size() : q2.size();
        if (sz == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_result_dut%0d: got 0x%0h, expected no result (t=%0t)",
                     id, act_res, $time);
        end else begin
            case (id)
                0:       e = q0.pop_front();
                1:       e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
            check($sformatf("res_dut%0d", id), act_res, e.res);
            check($sformatf("res_last_dut%0d", id), 64'(act_last), 64'(e.last));
        end
    endtask

    always @(negedge clk) if (if0.res_vld && if0.res_rdy) check_out(0, 64'(if0.res), if0.res_last);
    always @(negedge clk) if (if1.res_vld && if1.res_rdy) check_out(1, 64'(if1.res), if1.res_last);
    always @(negedge clk) if (if2.res_vld && if2.res_rdy) check_out(2, 64'(if2.res), if2.res_last);

    // ---------------- stimulus helpers (called at posedge + #1) ----------------
    function automatic logic [WIN_W-1:0] all_pix(input int v);
        logic [WIN_W-1:0] w;
        for (int i = 0; i < K * K; i++) w[i * DIN_W +: DIN_W] = DIN_W'(v);
        return w;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send0(input logic [WIN_W-1:0] w, input logic relu, input int b0,
                         input int b1, input int sel, input longint e0, input longint e1);
        int budget = 200;
        while (!if0.win_rdy && budget > 0) begin
            tick(1);
            budget--;
        end
        if (budget == 0) begin
            check("win_rdy_timeout_dut0", 64'(if0.win_rdy), 64'(1));
        end else begin
            if0.win     = w;
            if0.relu_en = relu;
            bias0       = {WT_W'(b1), WT_W'(b0)};
            wt_sel0     = sel;
            if0.win_vld = 1'b1;
            push_exp(0, e0, e1);
            tick(1);
            if0.win_vld = 1'b0;
        end
    endtask

    task automatic send_s(input int b0, input int b1, input int sel, input longint s0,
                          input longint s1, input longint w0, input longint w1);
        int budget = 200;
        while (!(if1.win_rdy && if2.win_rdy) && budget > 0) begin
            tick(1);
            budget--;
        end
        if (budget == 0) begin
            check("win_rdy_timeout_sat", 64'(if1.win_rdy && if2.win_rdy), 64'(1));
        end else begin
            if1.win = all_pix(3);
            if2.win = all_pix(3);
            bias_s   = {WT_W'(b1), WT_W'(b0)};
            wt_sel_s = sel;
            if1.win_vld = 1'b1;
            if2.win_vld = 1'b1;
            push_exp(1, s0, s1);
            push_exp(2, w0, w1);
            tick(1);
            if1.win_vld = 1'b0;
            if2.win_vld = 1'b0;
        end
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        flush_exp();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected $finish before 200000");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int pv [9];
        logic hold_ok;

        if0.win_vld = 0; if0.win = '0; if0.relu_en = 0; if0.res_rdy = 1;
        if1.win_vld = 0; if1.win = '0; if1.relu_en = 0; if1.res_rdy = 1;
        if2.win_vld = 0; if2.win = '0; if2.relu_en = 0; if2.res_rdy = 1;
        bias0 = '0;
        bias_s = '0;
        tick(3);
        rst_n = 1'b1;
        tick(1);

        // Reset state
        check("rst_win_rdy", 64'(if0.win_rdy), 64'(1));
        check("rst_res_vld", 64'(if0.res_vld), 64'(0));
        check("rst_res", 64'(if0.res), 64'(0));
        check("rst_res_last", 64'(if0.res_last), 64'(0));
        check("rst_busy", 64'(busy0), 64'(0));
        check("rst_wt_row_idx", 64'(wt_idx0), 64'(0));

        // All ones, ch0 +1 / ch1 -1, bias {5,2}: {ch1,ch0} = {-7,14}; latency walk
        send0(all_pix(1), 1'b0, 5, 2, 0, 14, -7);
        check("mac_busy", 64'(busy0), 64'(1));
        check("mac_win_rdy", 64'(if0.win_rdy), 64'(0));
        check("mac_row0", 64'(wt_idx0), 64'(0));
        tick(1);
        check("mac_row1", 64'(wt_idx0), 64'(1));
        tick(1);
        check("mac_row2", 64'(wt_idx0), 64'(2));
        tick(1);
        check("write_res_vld_early", 64'(if0.res_vld), 64'(0));
        check("write_row_idx", 64'(wt_idx0), 64'(0));
        tick(1);
        check("res_vld_at_k_plus_1", 64'(if0.res_vld), 64'(1));
        check("idle_busy", 64'(busy0), 64'(0));

        // ReLU variant, row-dependent weights, extreme weights
        send0(all_pix(1), 1'b1, 5, 2, 0, 14, 0);
        pv = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
        begin
            logic [WIN_W-1:0] wv;
            for (int i = 0; i < K * K; i++) wv[i * DIN_W +: DIN_W] = DIN_W'(pv[i]);
            send0(wv, 1'b0, -10, 0, 1, 16, -2);
            send0(wv, 1'b1, -10, 0, 1, 16, 0);
        end
        send0(all_pix(3), 1'b0, -256, 255, 2, -7168, 7140);
        tick(12);

        // Saturate (dut1) vs wrap (dut2), ACC_W = 12
        send_s(0, 0, 3, 2047, 2047, 2789, 2789);
        send_s(-256, 255, 2, -2048, 2047, 1024, 3044);
        send_s(0, -256, 3, 2047, 1791, 2789, 2533);
        tick(12);

        // Reset in the middle of MAC: window discarded, no spurious result
        send0(all_pix(1), 1'b0, 5, 2, 0, 14, -7);
        tick(1);
        rst_n = 1'b0;
        flush_exp();
        tick(2);
        rst_n = 1'b1;
        tick(1);
        check("midmac_rst_win_rdy", 64'(if0.win_rdy), 64'(1));
        check("midmac_rst_res_vld", 64'(if0.res_vld), 64'(0));
        check("midmac_rst_busy", 64'(busy0), 64'(0));
        tick(10);
        check("midmac_rst_no_result", 64'(if0.res_vld), 64'(0));

        // FRAME_LEN = 3: last flag on results 3 and 6 of 7
        pulse_clr();
        for (int i = 0; i < 7; i++) send0(all_pix(i % 4), 1'b0, 0, 0, 0, 9 * (i % 4), -9 * (i % 4));
        tick(12);

        // FIFO full: 4 accepted, 5th held off until one pop, ordering kept
        if0.res_rdy = 1'b0;
        for (int i = 0; i < 4; i++) send0(all_pix(i), 1'b0, 0, 0, 0, 9 * i, -9 * i);
        if0.win = all_pix(2);
        if0.win_vld = 1'b1;
        hold_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (if0.win_rdy) hold_ok = 1'b0;
        end
        if0.win_vld = 1'b0;
        check("fifo_full_holdoff", 64'(hold_ok), 64'(1));
        check("fifo_full_res_vld", 64'(if0.res_vld), 64'(1));
        if0.res_rdy = 1'b1;
        tick(1);
        if0.res_rdy = 1'b0;
        check("fifo_pop_reenables", 64'(if0.win_rdy), 64'(1));
        send0(all_pix(1), 1'b0, 5, 2, 0, 14, -7);
        if0.res_rdy = 1'b1;
        send0(all_pix(3), 1'b0, 0, 0, 0, 27, -27);
        tick(20);

        // clr one cycle after accept
        send0(all_pix(2), 1'b0, 0, 0, 0, 18, -18);
        pulse_clr();
        check("clr_inflight_res_vld", 64'(if0.res_vld), 64'(0));
        check("clr_inflight_busy", 64'(busy0), 64'(0));
        check("clr_inflight_win_rdy", 64'(if0.win_rdy), 64'(1));
        tick(8);
        check("clr_inflight_no_result", 64'(if0.res_vld), 64'(0));

        // clr with two results queued; frame index restarts at 0
        if0.res_rdy = 1'b0;
        send0(all_pix(1), 1'b0, 0, 0, 0, 9, -9);
        send0(all_pix(2), 1'b0, 0, 0, 0, 18, -18);
        tick(5);
        check("clr_queued_res_vld_before", 64'(if0.res_vld), 64'(1));
        pulse_clr();
        check("clr_queued_res_vld", 64'(if0.res_vld), 64'(0));
        check("clr_queued_res", 64'(if0.res), 64'(0));
        check("clr_queued_res_last", 64'(if0.res_last), 64'(0));
        if0.res_rdy = 1'b1;
        for (int i = 1; i <= 3; i++) send0(all_pix(i), 1'b0, 0, 0, 0, 9 * i, -9 * i);
        tick(12);

        check("drain_dut0", 64'(q0.size()), 64'(0));
        check("drain_dut1", 64'(q1.size()), 64'(0));
        check("drain_dut2", 64'(q2.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/conv_engine_n.md
# conv_engine_n

Parametrised convolution engine for the CNN pipeline. It accepts one K×K input window per handshake and computes OUT_CH output channels in parallel, one kernel row per cycle. It adds a per-channel bias, applies optional ReLU, and buffers results in an output FIFO with a per-frame last flag. It replaces the fixed 3×3 / 2-channel first layer and is meant for any layer whose weights come from external row-addressed ROMs.

## Interface
- K, 3, kernel size (rows = cols = K, K ≥ 2)
- OUT_CH, 2, output channels computed in parallel
- DIN_W, 2, input pixel width, unsigned
- WT_W, 9, weight/bias width, signed two's complement
- ACC_W, 18, accumulator/result width, signed
- SAT, 0, 0 = modulo-2^ACC_W wrap, 1 = saturate every add to signed ACC_W range
- FIFO_DEPTH, 4, output FIFO entries (power of 2)
- FRAME_LEN, 676, results per frame
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- clr  in  1  synchronous flush (end of image)
- relu_en  in  1  1 = clamp negative results to 0; sampled at window accept
- win_vld  in  1  window valid
- win_rdy  out  1  engine can accept window
- win  in  K*K*DIN_W  window, pixel (r,c) at bits [(r*K+c)*DIN_W +: DIN_W]
- wt_row_idx  out  $clog2(K)  kernel row currently addressed
- wt_row  in  OUT_CH*K*WT_W  weights for row wt_row_idx, combinational source; ch o, col c at [(o*K+c)*WT_W +: WT_W]
- bias  in  OUT_CH*WT_W  per-channel bias, static during a frame
- res_vld  out  1  FIFO non-empty
- res_rdy  in  1  consumer pop
- res  out  OUT_CH*ACC_W  FIFO head, ch o at [o*ACC_W +: ACC_W]
- res_last  out  1  head is the FRAME_LEN-th result of the frame
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, MAC, WRITE.
- IDLE: win_rdy = !fifo_full. When win_vld && win_rdy: capture win and relu_en, clear accumulators, row = 0, go to MAC.
- MAC: wt_row_idx = row. For each o, acc[o] += Σ_c sext(zext(pix(row,c)) × w(o,c)). On row == K-1 go to WRITE; otherwise row++.
- WRITE: y[o] = acc[o] + sext(bias[o]). If relu_en, y[o] = max(y[o], 0). Push y with last = (frame_cnt == FRAME_LEN-1). frame_cnt wraps to 0 after the last result. Go to IDLE.
- Arithmetic: products are exact. SAT=0: all adds wrap mod 2^ACC_W. SAT=1: each add clamps to [−2^(ACC_W−1), 2^(ACC_W−1)−1].
- FIFO: the push in WRITE never meets a full FIFO, because fullness is checked at accept and only pops occur in between. A simultaneous push and pop keeps the count unchanged.
- clr has priority over everything. It forces state to IDLE, clears row, accumulators and frame_cnt, and empties the FIFO. An in-flight window is discarded.
- wt_row_idx = 0 outside MAC.

## Timing
- Reset values: win_rdy=1 (FIFO empty, IDLE), res_vld=0, res=0, res_last=0, busy=0, wt_row_idx=0. frame_cnt=0, accumulators=0.
- Window accepted on edge E. Row r accumulates on edge E+1+r. Push on edge E+K+1, so res_vld is high from E+K+1 with an empty FIFO.
- Throughput: one window per K+2 cycles. win_rdy is 0 during MAC and WRITE.
- Pop on any edge with res_vld && res_rdy. res and res_last show the next entry in the following cycle (first-word-fall-through).
- clr asserted on edge T: every output equals its reset value after T.

## Structure
- Package cnn_pkg holds:
  - the state enum typedef;
  - a sat_add function (width-parametrised via ACC_W argument);
  - FRAME_LEN default constants per layer.
- Sub-module cnn_fifo: parametrised synchronous FWFT FIFO (data width, depth, sync clr) storing {last, res}.
- MAC/bias/ReLU stay inline as generate loops over OUT_CH.

## Test plan
- Reset: hold rst_n low mid-MAC, release → win_rdy=1, res_vld=0, busy=0, no spurious result.
- Defaults, all pixels 1, ch0 weights +1, ch1 weights −1, bias {5,2}, relu_en=0 → res = {−7, 14}, res_vld 4 cycles after accept. Repeat with relu_en=1 → {0, 14}.
- SAT=1, ACC_W=12, pixels 3, weights 255, bias 0 → both channels 2047. Same with SAT=0 → 6885 mod 4096 = 2789.
- FIFO_DEPTH=4, res_rdy=0, 6 windows offered → 4 accepted, win_rdy stays 0. Single pop re-enables accept. Results come out in order.
- FRAME_LEN=3, 7 windows → res_last only on results 3 and 6.
- clr one cycle after accept and with 2 entries queued → res_vld=0 next cycle, next result has frame index 0, no stale data.
